// File: rtl/wb_write_port_arbiter_pkg.sv
// Shared types and constants for the register-file write-port arbiter.
package wb_write_port_arbiter_pkg;

    localparam logic [4:0] XZR    = 5'd31;
    localparam int         DATA_W = 64;

    typedef struct packed {
        logic reg_write;
    } struct_WB;

    typedef struct packed {
        logic              valid;
        logic [4:0]        Rd;
        logic [DATA_W-1:0] data;
    } struct_WBQ;

    typedef enum logic [1:0] {
        WBA_IDLE  = 2'd0,
        WBA_WAIT  = 2'd1,
        WBA_STALL = 2'd2
    } wba_state_t;

endpackage

// File: rtl/wb_write_port_arbiter_if.sv
// Bundle of WB-stage, LLU, register-file and hazard-query signals around the arbiter.
interface wb_write_port_arbiter_if;
    import wb_write_port_arbiter_pkg::*;

    logic [DATA_W-1:0] wb_write_data;
    logic [4:0]        wb_Rd;
    struct_WB          wb_WB;
    logic              ll_valid;
    logic              ll_ready;
    logic [4:0]        ll_Rd;
    logic [DATA_W-1:0] ll_data;
    logic [DATA_W-1:0] id_write_data;
    logic [4:0]        id_write_reg;
    logic              id_reg_write;
    logic              pipe_stall;
    logic [4:0]        q_Rd;
    logic              q_pending;

    modport master (
        output wb_write_data, wb_Rd, wb_WB, ll_valid, ll_Rd, ll_data, q_Rd,
        input  ll_ready, id_write_data, id_write_reg, id_reg_write, pipe_stall, q_pending
    );

    modport slave (
        input  wb_write_data, wb_Rd, wb_WB, ll_valid, ll_Rd, ll_data, q_Rd,
        output ll_ready, id_write_data, id_write_reg, id_reg_write, pipe_stall, q_pending
    );

endinterface

// File: rtl/wb_write_port_arbiter_wb_result_queue.sv
// LLU result FIFO. Entries are kept compacted at the low indices, so killed entries
// vanish at the next edge and the head (index 0) is always a live entry when valid.
module wb_result_queue
    import wb_write_port_arbiter_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push_i,
    input  logic [4:0]        push_rd_i,
    input  logic [DATA_W-1:0] push_data_i,
    input  logic              pop_i,
    input  logic              kill_i,
    input  logic [4:0]        kill_rd_i,
    input  logic [4:0]        q_rd_i,
    output struct_WBQ         head_o,
    output logic [CNT_W-1:0]  count_o,
    output logic [CNT_W-1:0]  count_next_o,
    output logic              match_o
);

    struct_WBQ        ent_q [DEPTH];
    struct_WBQ        ent_d [DEPTH];
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic [CNT_W-1:0] n;
    logic             keep;

    // Next queue image: drop popped/killed entries, close the gaps, append the new push last.
    always_comb begin
        n    = '0;
        keep = 1'b0;
        for (int j = 0; j < DEPTH; j++) begin
            ent_d[j]       = ent_q[j];
            ent_d[j].valid = 1'b0;
        end
        for (int i = 0; i < DEPTH; i++) begin
            keep = ent_q[i].valid && !(pop_i && (i == 0))
                   && !(kill_i && (ent_q[i].Rd == kill_rd_i));
            if (keep) begin
                for (int j = 0; j < DEPTH; j++) begin
                    if (n == CNT_W'(j)) ent_d[j] = ent_q[i];
                end
                n = n + CNT_W'(1);
            end
        end
        if (push_i) begin
            for (int j = 0; j < DEPTH; j++) begin
                if (n == CNT_W'(j)) ent_d[j] = '{valid: 1'b1, Rd: push_rd_i, data: push_data_i};
            end
            n = n + CNT_W'(1);
        end
        count_d = n;
    end

    // Queue storage; reset only clears occupancy, payloads are don't-care when invalid.
    always_ff @(posedge clk) begin
        count_q <= count_d;
        for (int j = 0; j < DEPTH; j++) ent_q[j] <= ent_d[j];
        if (rst) begin
            count_q <= '0;
            for (int j = 0; j < DEPTH; j++) ent_q[j].valid <= 1'b0;
        end
    end

    // Hazard query over registered entries only; XZR never counts as pending.
    always_comb begin
        match_o = 1'b0;
        for (int j = 0; j < DEPTH; j++) begin
            if (ent_q[j].valid && (ent_q[j].Rd == q_rd_i) && (q_rd_i != XZR)) match_o = 1'b1;
        end
    end

    assign head_o       = ent_q[0];
    assign count_o      = count_q;
    assign count_next_o = count_d;

endmodule

// File: rtl/wb_write_port_arbiter.sv
// Register-file write-port arbiter: pipeline WB writes win, queued LLU results drain
// into WB bubbles, and a starvation counter forces a bubble via pipe_stall.
module wb_write_port_arbiter
    import wb_write_port_arbiter_pkg::*;
#(
    parameter int DEPTH    = 4,
    parameter int MAX_WAIT = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    wb_write_port_arbiter_if.slave   bus
);

    localparam int CNT_W  = $clog2(DEPTH) + 1;
    localparam int WAIT_W = $clog2(MAX_WAIT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);

    localparam logic [1:0] ST_IDLE  = WBA_IDLE;
    localparam logic [1:0] ST_WAIT  = WBA_WAIT;
    localparam logic [1:0] ST_STALL = WBA_STALL;

    logic [1:0]        state_q, state_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic              pipe_wr, drain, ready, accept, store, kill, match;
    struct_WBQ         head;
    logic [CNT_W-1:0]  count_q, count_d;

    assign pipe_wr = bus.wb_WB.reg_write && (bus.wb_Rd != XZR);
    assign ready   = !rst && (count_q < CNT_W'(DEPTH));
    assign drain   = !rst && !pipe_wr && head.valid;
    assign accept  = bus.ll_valid && ready;
    assign store   = accept && (bus.ll_Rd != XZR);
    assign kill    = !rst && pipe_wr;

    wb_result_queue #(.DEPTH(DEPTH)) u_queue (
        .clk          (clk),
        .rst          (rst),
        .push_i       (store),
        .push_rd_i    (bus.ll_Rd),
        .push_data_i  (bus.ll_data),
        .pop_i        (drain),
        .kill_i       (kill),
        .kill_rd_i    (bus.wb_Rd),
        .q_rd_i       (bus.q_Rd),
        .head_o       (head),
        .count_o      (count_q),
        .count_next_o (count_d),
        .match_o      (match)
    );

    // Write-port mux: pipeline first, then queue head, otherwise an XZR no-op.
    always_comb begin
        bus.id_reg_write  = 1'b0;
        bus.id_write_reg  = XZR;
        bus.id_write_data = '0;
        if (rst) begin
            bus.id_write_reg = 5'd0;
        end else if (pipe_wr) begin
            bus.id_reg_write  = 1'b1;
            bus.id_write_reg  = bus.wb_Rd;
            bus.id_write_data = bus.wb_write_data;
        end else if (head.valid) begin
            bus.id_reg_write  = 1'b1;
            bus.id_write_reg  = head.Rd;
            bus.id_write_data = head.data;
        end
    end

    // Starvation FSM; the queue occupancy after this edge decides a return to IDLE.
    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        case (state_q)
            ST_IDLE: begin
                if (count_d != '0) begin
                    state_d = ST_WAIT;
                    wait_d  = '0;
                end
            end
            ST_WAIT: begin
                if (count_d == '0) begin
                    state_d = ST_IDLE;
                    wait_d  = '0;
                end else if (drain) begin
                    wait_d = '0;
                end else if (wait_q == WAIT_LAST) begin
                    state_d = ST_STALL;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            ST_STALL: begin
                if (count_d == '0) begin
                    state_d = ST_IDLE;
                    wait_d  = '0;
                end else if (drain) begin
                    state_d = ST_WAIT;
                    wait_d  = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                wait_d  = '0;
            end
        endcase
    end

    // FSM state and wait counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
        end
    end

    // Stall is raised on the last allowed waiting cycle and held until a drain.
    assign bus.pipe_stall = !rst && ((state_q == ST_STALL)
                            || ((state_q == ST_WAIT) && (wait_q == WAIT_LAST)));
    assign bus.ll_ready   = ready;
    assign bus.q_pending  = !rst && match;

endmodule

// File: tb/tb_wb_write_port_arbiter.sv
// Testbench for wb_write_port_arbiter: directed scenarios plus randomized traffic
// compared every cycle against a queue-based behavioural model.
module tb_wb_write_port_arbiter;
    import wb_write_port_arbiter_pkg::*;

    localparam int DEPTH    = 4;
    localparam int MAX_WAIT = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    wb_write_port_arbiter_if bus();

    wb_write_port_arbiter #(.DEPTH(DEPTH), .MAX_WAIT(MAX_WAIT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    // Behavioural model: surviving queued writes in FIFO order, and the number of
    // consecutive cycles the queue has been non-empty without a drain.
    logic [4:0]  m_rd  [$];
    logic [63:0] m_dat [$];
    int          m_w = 0;
    logic [63:0] rf [32];

    task automatic cmp(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model state update on each rising edge from the inputs held during the cycle.
    always @(posedge clk) begin
        bit pw, dr, acc;
        int n;
        pw = bus.wb_WB.reg_write && (bus.wb_Rd != XZR);
        if (rst) begin
            m_rd.delete();
            m_dat.delete();
            m_w = 0;
        end else begin
            n   = m_rd.size();
            acc = bus.ll_valid && (n < DEPTH);
            dr  = !pw && (n > 0);
            if (pw) rf[bus.wb_Rd] = bus.wb_write_data;
            else if (dr) rf[m_rd[0]] = m_dat[0];
            if (dr) begin
                void'(m_rd.pop_front());
                void'(m_dat.pop_front());
            end
            if (pw) begin
                for (int i = m_rd.size() - 1; i >= 0; i--) begin
                    if (m_rd[i] == bus.wb_Rd) begin
                        m_rd.delete(i);
                        m_dat.delete(i);
                    end
                end
            end
            if (acc && (bus.ll_Rd != XZR)) begin
                m_rd.push_back(bus.ll_Rd);
                m_dat.push_back(bus.ll_data);
            end
            if ((m_rd.size() == 0) || dr || (n == 0)) m_w = 0;
            else m_w++;
        end
    end

    // Compare process: every cycle, on the falling edge.
    always @(negedge clk) begin
        logic        pw, ew, erdy, est, epd;
        logic [4:0]  er;
        logic [63:0] ed;
        int          n;
        pw   = bus.wb_WB.reg_write && (bus.wb_Rd != XZR);
        n    = m_rd.size();
        ew   = 1'b0;
        er   = XZR;
        ed   = '0;
        erdy = 1'b0;
        est  = 1'b0;
        epd  = 1'b0;
        if (rst) begin
            er = 5'd0;
        end else begin
            erdy = (n < DEPTH);
            if (pw) begin
                ew = 1'b1;
                er = bus.wb_Rd;
                ed = bus.wb_write_data;
            end else if (n > 0) begin
                ew = 1'b1;
                er = m_rd[0];
                ed = m_dat[0];
            end
            est = (n > 0) && (m_w >= MAX_WAIT - 1);
            if (bus.q_Rd != XZR) begin
                foreach (m_rd[i]) if (m_rd[i] == bus.q_Rd) epd = 1'b1;
            end
        end
        cmp("m_id_reg_write",  64'(bus.id_reg_write),  64'(ew));
        cmp("m_id_write_reg",  64'(bus.id_write_reg),  64'(er));
        cmp("m_id_write_data", bus.id_write_data,      ed);
        cmp("m_ll_ready",      64'(bus.ll_ready),      64'(erdy));
        cmp("m_pipe_stall",    64'(bus.pipe_stall),    64'(est));
        cmp("m_q_pending",     64'(bus.q_pending),     64'(epd));
    end

    // Apply one cycle of inputs just after the rising edge, then let outputs settle.
    task automatic drive(input bit r, input bit we, input logic [4:0] rd, input logic [63:0] d,
                         input bit lv, input logic [4:0] lrd, input logic [63:0] ld,
                         input logic [4:0] qrd);
        @(posedge clk);
        #1;
        rst                   = r;
        bus.wb_WB.reg_write   = we;
        bus.wb_Rd             = rd;
        bus.wb_write_data     = d;
        bus.ll_valid          = lv;
        bus.ll_Rd             = lrd;
        bus.ll_data           = ld;
        bus.q_Rd              = qrd;
        #2;
    endtask

    task automatic idle(input logic [4:0] qrd);
        drive(1'b0, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0, qrd);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit          seen;
        int          k;
        int          busy_pct;
        bit          r, we, lv;
        logic [4:0]  rd, lrd, qrd;

        rst = 1'b1;
        bus.wb_WB.reg_write = 1'b0;
        bus.wb_Rd = 5'd0;
        bus.wb_write_data = '0;
        bus.ll_valid = 1'b0;
        bus.ll_Rd = 5'd0;
        bus.ll_data = '0;
        bus.q_Rd = XZR;
        foreach (rf[i]) rf[i] = '0;

        // Reset: outputs forced low even with traffic offered.
        drive(1'b1, 1'b1, 5'd3, 64'h55, 1'b1, 5'd4, 64'h66, 5'd4);
        drive(1'b1, 1'b1, 5'd3, 64'h55, 1'b1, 5'd4, 64'h66, 5'd4);
        cmp("rst_reg_write", 64'(bus.id_reg_write), 64'd0);
        cmp("rst_write_reg", 64'(bus.id_write_reg), 64'd0);
        cmp("rst_ll_ready",  64'(bus.ll_ready),     64'd0);
        cmp("rst_stall",     64'(bus.pipe_stall),   64'd0);

        // 1: idle pipe, single LLU result drains one cycle later.
        drive(1'b0, 1'b0, 5'd0, 64'd0, 1'b1, 5'd5, 64'hAB, 5'd5);
        cmp("t1_accept_ready",   64'(bus.ll_ready),     64'd1);
        cmp("t1_accept_pending", 64'(bus.q_pending),    64'd0);
        cmp("t1_accept_we",      64'(bus.id_reg_write), 64'd0);
        idle(5'd5);
        cmp("t1_drain_we",      64'(bus.id_reg_write), 64'd1);
        cmp("t1_drain_reg",     64'(bus.id_write_reg), 64'd5);
        cmp("t1_drain_data",    bus.id_write_data,     64'hAB);
        cmp("t1_drain_pending", 64'(bus.q_pending),    64'd1);
        idle(5'd5);
        cmp("t1_after_we",      64'(bus.id_reg_write), 64'd0);
        cmp("t1_after_reg",     64'(bus.id_write_reg), 64'(XZR));
        cmp("t1_after_pending", 64'(bus.q_pending),    64'd0);

        // 2: busy pipe starves one entry until pipe_stall forces a bubble.
        drive(1'b0, 1'b1, 5'd1, 64'd100, 1'b1, 5'd9, 64'h99, XZR);
        seen = 1'b0;
        k = 0;
        for (int c = 1; c <= 20 && !seen; c++) begin
            drive(1'b0, 1'b1, 5'd1, 64'(c), 1'b0, 5'd0, 64'd0, XZR);
            if (bus.pipe_stall) begin
                seen = 1'b1;
                k = c;
            end
        end
        cmp("t2_stall_cycle", 64'(k), 64'd8);
        idle(XZR);
        cmp("t2_bubble_we",    64'(bus.id_reg_write), 64'd1);
        cmp("t2_bubble_reg",   64'(bus.id_write_reg), 64'd9);
        cmp("t2_bubble_data",  bus.id_write_data,     64'h99);
        cmp("t2_bubble_stall", 64'(bus.pipe_stall),   64'd1);
        idle(XZR);
        cmp("t2_after_stall",  64'(bus.pipe_stall),   64'd0);
        cmp("t2_after_we",     64'(bus.id_reg_write), 64'd0);

        // 3: fill the queue behind a busy pipe, then drain in FIFO order.
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b1, 5'd1, 64'd7, 1'b1, 5'(10 + i), 64'(32'hA0 + i), XZR);
            cmp("t3_fill_ready", 64'(bus.ll_ready), 64'd1);
        end
        drive(1'b0, 1'b1, 5'd1, 64'd7, 1'b1, 5'd14, 64'hEE, XZR);
        cmp("t3_full_ready", 64'(bus.ll_ready), 64'd0);
        idle(XZR);
        cmp("t3_d0_reg",   64'(bus.id_write_reg), 64'd10);
        cmp("t3_d0_data",  bus.id_write_data,     64'hA0);
        cmp("t3_d0_ready", 64'(bus.ll_ready),     64'd0);
        idle(XZR);
        cmp("t3_d1_ready", 64'(bus.ll_ready),     64'd1);
        cmp("t3_d1_reg",   64'(bus.id_write_reg), 64'd11);
        idle(XZR);
        cmp("t3_d2_reg",   64'(bus.id_write_reg), 64'd12);
        idle(XZR);
        cmp("t3_d3_reg",   64'(bus.id_write_reg), 64'd13);
        cmp("t3_d3_data",  bus.id_write_data,     64'hA3);
        idle(XZR);
        cmp("t3_empty_we", 64'(bus.id_reg_write), 64'd0);

        // 4: younger pipeline write kills a queued entry; XZR pushes vanish;
        //    a same-cycle push to the written register survives.
        drive(1'b0, 1'b0, 5'd0, 64'd0, 1'b1, 5'd7, 64'h11, 5'd7);
        drive(1'b0, 1'b1, 5'd7, 64'h22, 1'b0, 5'd0, 64'd0, 5'd7);
        cmp("t4_kill_data",    bus.id_write_data,   64'h22);
        cmp("t4_kill_pending", 64'(bus.q_pending),  64'd1);
        idle(5'd7);
        cmp("t4_killed_we",      64'(bus.id_reg_write), 64'd0);
        cmp("t4_killed_pending", 64'(bus.q_pending),    64'd0);
        drive(1'b0, 1'b0, 5'd0, 64'd0, 1'b1, XZR, 64'h77, XZR);
        cmp("t4_xzr_ready", 64'(bus.ll_ready), 64'd1);
        idle(XZR);
        cmp("t4_xzr_we", 64'(bus.id_reg_write), 64'd0);
        drive(1'b0, 1'b1, 5'd8, 64'h44, 1'b1, 5'd8, 64'h33, 5'd8);
        cmp("t4_same_pending", 64'(bus.q_pending), 64'd0);
        idle(5'd8);
        cmp("t4_same_reg",  64'(bus.id_write_reg), 64'd8);
        cmp("t4_same_data", bus.id_write_data,     64'h33);
        idle(XZR);
        cmp("t4_rf7", rf[7], 64'h22);
        cmp("t4_rf8", rf[8], 64'h33);

        // 5: reset in the middle of a stall with three entries queued.
        for (int i = 0; i < 3; i++)
            drive(1'b0, 1'b1, 5'd1, 64'd5, 1'b1, 5'(20 + i), 64'(32'hC0 + i), XZR);
        seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            drive(1'b0, 1'b1, 5'd1, 64'd5, 1'b0, 5'd0, 64'd0, 5'd20);
            if (bus.pipe_stall) seen = 1'b1;
        end
        cmp("t5_stall_seen", 64'(seen), 64'd1);
        drive(1'b1, 1'b1, 5'd1, 64'd5, 1'b1, 5'd3, 64'd9, 5'd20);
        cmp("t5_rst_we",      64'(bus.id_reg_write),  64'd0);
        cmp("t5_rst_data",    bus.id_write_data,      64'd0);
        cmp("t5_rst_stall",   64'(bus.pipe_stall),    64'd0);
        cmp("t5_rst_pending", 64'(bus.q_pending),     64'd0);
        idle(5'd20);
        cmp("t5_post_we",      64'(bus.id_reg_write), 64'd0);
        cmp("t5_post_stall",   64'(bus.pipe_stall),   64'd0);
        cmp("t5_post_ready",   64'(bus.ll_ready),     64'd1);
        cmp("t5_post_pending", 64'(bus.q_pending),    64'd0);

        // Randomized traffic with varying pipeline load and occasional resets.
        busy_pct = 50;
        for (int c = 0; c < 4000; c++) begin
            if ((c % 100) == 0) busy_pct = $urandom_range(20, 98);
            r   = ($urandom_range(0, 299) == 0);
            we  = ($urandom_range(0, 99) < busy_pct);
            rd  = ($urandom_range(0, 9) == 0) ? XZR : 5'($urandom_range(0, 7));
            lv  = ($urandom_range(0, 1) == 1);
            lrd = ($urandom_range(0, 9) == 0) ? XZR : 5'($urandom_range(0, 7));
            qrd = ($urandom_range(0, 7) == 0) ? XZR : 5'($urandom_range(0, 7));
            drive(r, we, rd, {$urandom, $urandom}, lv, lrd, {$urandom, $urandom}, qrd);
        end
        idle(XZR);
        @(posedge clk);
        #1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
